// File: rtl/decoder_scan_mux_if.sv
// -----------------------------------------------------------------------------
// decoder_scan_mux_if
//
// Purpose : groups the frame-load handshake and the multiplexed display
//           outputs of decoder_scan_mux into one bundle.
//
// Signals : load_valid  host presents a new frame
//           load_ready  block can accept a frame (combinational from pending)
//           load_data   CHANNELS nibbles, digit k at [4k+3:4k]
//           blank_mask  bit k=1 forces digit k dark, sampled with load_data
//           seg_out     segment pattern, bit0=a .. bit6=g, 1 = lit
//           digit_en    one-hot enable of the digit currently lit
//           frame_done  one-cycle pulse on the first cycle of digit 0
//
// Modports: master - host / display side (drives the load request)
//           slave  - decoder_scan_mux itself
// -----------------------------------------------------------------------------
interface decoder_scan_mux_if #(
    parameter int CHANNELS = 4
);
    logic                  load_valid;
    logic                  load_ready;
    logic [4*CHANNELS-1:0] load_data;
    logic [CHANNELS-1:0]   blank_mask;
    logic [6:0]            seg_out;
    logic [CHANNELS-1:0]   digit_en;
    logic                  frame_done;

    modport master (
        output load_valid,
        output load_data,
        output blank_mask,
        input  load_ready,
        input  seg_out,
        input  digit_en,
        input  frame_done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  blank_mask,
        output load_ready,
        output seg_out,
        output digit_en,
        output frame_done
    );
endinterface

// File: rtl/decoder_scan_mux.sv
// -----------------------------------------------------------------------------
// decoder_scan_mux
//
// Purpose : accepts a frame of CHANNELS hex nibbles over a valid/ready port,
//           decodes them to 7-segment patterns and scans them out one digit at
//           a time. Each digit stays lit for PRESCALE cycles. A newly loaded
//           frame waits in a pending register and only becomes visible at a
//           frame boundary, so a frame is never shown half old / half new.
//
// Ports   : i_clock    system clock, rising edge
//           i_reset_n  asynchronous active-low reset
//           bus        decoder_scan_mux_if.slave (load handshake + display)
//
// Parameters:
//           CHANNELS   number of digits scanned (2..8)
//           PRESCALE   cycles each digit stays lit (>= 2, fits 16 bits)
//
// Build option:
//           DECODER_LEADING_ZERO_BLANK_EN - when defined, zero digits above
//           the most significant nonzero digit are blanked as well (digit 0
//           is always shown). The mask is computed once, as the frame moves
//           into the active register. Undefined: only blank_mask blanks.
// -----------------------------------------------------------------------------
module decoder_scan_mux #(
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 1000
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    decoder_scan_mux_if.slave bus
);

    localparam int                IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [15:0]       PRESC_LAST = 16'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(CHANNELS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    // -------------------------------------------------------------------------
    // Registers and their next-state values
    // -------------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_pend_valid;
    logic                  w_pend_valid_nxt;
    logic [4*CHANNELS-1:0] r_pend_data;
    logic [4*CHANNELS-1:0] w_pend_data_nxt;
    logic [CHANNELS-1:0]   r_pend_mask;
    logic [CHANNELS-1:0]   w_pend_mask_nxt;

    logic [4*CHANNELS-1:0] r_act_data;
    logic [4*CHANNELS-1:0] w_act_data_nxt;
    // Final per-digit blanking of the active frame (mask plus optional
    // leading-zero rule), frozen for the whole frame.
    logic [CHANNELS-1:0]   r_act_blank;
    logic [CHANNELS-1:0]   w_act_blank_nxt;

    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [15:0]           r_presc;
    logic [15:0]           w_presc_nxt;

    logic [6:0]            r_seg;
    logic [6:0]            w_seg_nxt;
    logic [CHANNELS-1:0]   r_digit_en;
    logic [CHANNELS-1:0]   w_digit_en_nxt;
    logic                  r_frame_done;
    logic                  w_frame_done_nxt;

    // -------------------------------------------------------------------------
    // Helper wires
    // -------------------------------------------------------------------------
    logic                  w_accept;   // load handshake completes this edge
    logic                  w_promote;  // pending frame moves to active this edge
    logic                  w_presc_tc; // last cycle of the current digit slot
    logic [3:0]            w_nibble;   // nibble of the digit lit next cycle
    logic                  w_blank;    // that digit is dark next cycle
    logic [CHANNELS-1:0]   w_frame_blank;

    // -------------------------------------------------------------------------
    // Standard hex to 7-segment table, bit0=a .. bit6=g, active high.
    // -------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

`ifdef DECODER_LEADING_ZERO_BLANK_EN
    // Walk from the most significant digit down; keep blanking while every
    // digit seen so far is zero. Digit 0 is excluded so a value of zero
    // still shows a single "0".
    function automatic logic [CHANNELS-1:0] lead_zero_mask(
        input logic [4*CHANNELS-1:0] data
    );
        logic [CHANNELS-1:0] mask;
        logic                still_zero;
        mask       = '0;
        still_zero = 1'b1;
        for (int k = CHANNELS - 1; k >= 1; k--) begin
            still_zero = still_zero && (data[4*k +: 4] == 4'h0);
            mask[k]    = still_zero;
        end
        return mask;
    endfunction
`endif

    // Blanking for the frame that is about to become active.
    always_comb begin
`ifdef DECODER_LEADING_ZERO_BLANK_EN
        w_frame_blank = r_pend_mask | lead_zero_mask(r_pend_data);
`else
        w_frame_blank = r_pend_mask;
`endif
    end

    // -------------------------------------------------------------------------
    // Next-state logic: scan FSM, prescaler, pending/active frame handling
    // and the values the registered outputs take on the next edge.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_presc_nxt      = r_presc;
        w_promote        = 1'b0;
        w_frame_done_nxt = 1'b0;

        w_accept   = bus.load_valid && !r_pend_valid;
        w_presc_tc = (r_presc == PRESC_LAST);

        case (r_state)
            ST_IDLE: begin
                // First frame goes live one edge after it is accepted.
                if (r_pend_valid) begin
                    w_promote   = 1'b1;
                    w_state_nxt = ST_SCAN;
                    w_idx_nxt   = '0;
                    w_presc_nxt = '0;
                end
            end

            ST_SCAN: begin
                if (w_presc_tc) begin
                    w_presc_nxt = '0;
                    if (r_idx == IDX_LAST) begin
                        // Frame boundary: the only point where new data may
                        // replace the displayed frame.
                        w_idx_nxt        = '0;
                        w_frame_done_nxt = 1'b1;
                        w_promote        = r_pend_valid;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_presc_nxt = r_presc + 16'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Pending register. Accept and promote are mutually exclusive (accept
        // needs pending clear, promote needs it set), so a load taken on a
        // boundary edge simply stays pending until the next boundary.
        w_pend_valid_nxt = r_pend_valid;
        w_pend_data_nxt  = r_pend_data;
        w_pend_mask_nxt  = r_pend_mask;
        if (w_promote) begin
            w_pend_valid_nxt = 1'b0;
        end
        if (w_accept) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_data_nxt  = bus.load_data;
            w_pend_mask_nxt  = bus.blank_mask;
        end

        // Active register.
        w_act_data_nxt  = r_act_data;
        w_act_blank_nxt = r_act_blank;
        if (w_promote) begin
            w_act_data_nxt  = r_pend_data;
            w_act_blank_nxt = w_frame_blank;
        end

        // Outputs are computed from the next index and next active frame so
        // that the registered outputs line up with the digit slot exactly.
        w_nibble = 4'h0;
        w_blank  = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_idx_nxt == IDX_W'(k)) begin
                w_nibble = w_act_data_nxt[4*k +: 4];
                w_blank  = w_act_blank_nxt[k];
            end
        end

        w_seg_nxt      = '0;
        w_digit_en_nxt = '0;
        if (w_state_nxt == ST_SCAN) begin
            for (int k = 0; k < CHANNELS; k++) begin
                // A blanked digit keeps its enable so every slot has the
                // same on-time regardless of content.
                w_digit_en_nxt[k] = (w_idx_nxt == IDX_W'(k));
            end
            if (!w_blank) begin
                w_seg_nxt = hex_to_seg(w_nibble);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            // NOTE: the frame registers are cleared too; a reset must drop
            // any pending frame rather than show stale data after release.
            r_state      <= ST_IDLE;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_pend_mask  <= '0;
            r_act_data   <= '0;
            r_act_blank  <= '0;
            r_idx        <= '0;
            r_presc      <= '0;
            r_seg        <= '0;
            r_digit_en   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state      <= w_state_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_data  <= w_pend_data_nxt;
            r_pend_mask  <= w_pend_mask_nxt;
            r_act_data   <= w_act_data_nxt;
            r_act_blank  <= w_act_blank_nxt;
            r_idx        <= w_idx_nxt;
            r_presc      <= w_presc_nxt;
            r_seg        <= w_seg_nxt;
            r_digit_en   <= w_digit_en_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.load_ready = !r_pend_valid;
    assign bus.seg_out    = r_seg;
    assign bus.digit_en   = r_digit_en;
    assign bus.frame_done = r_frame_done;

endmodule
